// File: rtl/axi4_s_rd_sequencer_if.sv
// Signal bundle between the read sequencer and its AR/R FIFOs and register targets.
// The slave modport is the sequencer's view; the master modport is the surrounding logic.
interface axi4_s_rd_sequencer_if #(
  parameter int unsigned A_W = 32,
  parameter int unsigned D_W = 32,
  parameter int unsigned N   = 4
);
  logic             ar_rd_empty;
  logic [A_W-1:0]   araddr;
  logic             ar_rd_en;
  logic             r_wr_full;
  logic             r_wr_en;
  logic [D_W-1:0]   rdata;
  logic [1:0]       rresp;
  logic [N-1:0]     tgt_en;
  logic [N-1:0]     tgt_req;
  logic [A_W-1:0]   tgt_addr;
  logic [N-1:0]     tgt_ack;
  logic [N*D_W-1:0] tgt_rdata;
  logic [N-1:0]     tgt_err;
  logic             busy;

  modport slave (
    input  ar_rd_empty, araddr, r_wr_full, tgt_en, tgt_ack, tgt_rdata, tgt_err,
    output ar_rd_en, r_wr_en, rdata, rresp, tgt_req, tgt_addr, busy
  );

  modport master (
    output ar_rd_empty, araddr, r_wr_full, tgt_en, tgt_ack, tgt_rdata, tgt_err,
    input  ar_rd_en, r_wr_en, rdata, rresp, tgt_req, tgt_addr, busy
  );
endinterface

// File: rtl/axi4_s_rd_sequencer.sv
// AXI4-lite slave read sequencer: pops one AR entry, runs a req/ack handshake with the
// decoded register target (with timeout), then pushes data/response into the R FIFO.
module axi4_s_rd_sequencer #(
  parameter int unsigned A_W     = 32,
  parameter int unsigned D_W     = 32,
  parameter int unsigned N       = 4,
  parameter int unsigned TGT_LSB = 12,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  axi4_s_rd_sequencer_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, PUSH} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, ar_idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [A_W-1:0]   addr_q, addr_d;
  logic [D_W-1:0]   rdata_q, rdata_d;
  logic [1:0]       rresp_q, rresp_d;
  logic [N-1:0]     req_q, req_d;
  logic             pop, push;

  always_comb begin
    ar_idx = bus.araddr[TGT_LSB +: IDX_W];
    pop    = aresetn && (state_q == IDLE) && !bus.ar_rd_empty;
    push   = aresetn && (state_q == PUSH) && !bus.r_wr_full;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    req_d   = req_q;
    unique case (state_q)
      IDLE: begin
        if (!bus.ar_rd_empty) begin
          addr_d = bus.araddr;
          idx_d  = ar_idx;
          cnt_d  = '0;
          if (bus.tgt_en[ar_idx]) begin
            req_d   = N'(1) << ar_idx;
            state_d = REQ;
          end else begin
            // Unpopulated target: answer DECERR without touching any target.
            rdata_d = '0;
            rresp_d = 2'b11;
            state_d = PUSH;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Ack is checked first so an ack in the last allowed cycle beats the timeout.
        if (bus.tgt_ack[idx_q]) begin
          rdata_d = bus.tgt_rdata[idx_q*D_W +: D_W];
          rresp_d = bus.tgt_err[idx_q] ? 2'b10 : 2'b00;
          req_d   = '0;
          state_d = PUSH;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rdata_d = '0;
          rresp_d = 2'b10;
          req_d   = '0;
          state_d = PUSH;
        end
      end
      PUSH: begin
        if (!bus.r_wr_full) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      rresp_q <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      req_q   <= req_d;
    end
  end

  assign bus.ar_rd_en = pop;
  assign bus.r_wr_en  = push;
  assign bus.rdata    = rdata_q;
  assign bus.rresp    = rresp_q;
  assign bus.tgt_req  = req_q;
  assign bus.tgt_addr = addr_q;
  assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_axi4_s_rd_sequencer.sv
// Scoreboard bench for axi4_s_rd_sequencer: AR/R FIFO and register-target models drive the
// DUT; expected responses are queued when reads are issued and checked at each R push.
module tb_axi4_s_rd_sequencer;
  localparam int unsigned A_W     = 32;
  localparam int unsigned D_W     = 32;
  localparam int unsigned N       = 4;
  localparam int unsigned TGT_LSB = 12;
  localparam int unsigned TIMEOUT = 8;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
    int          len;
    int          stall;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0, failures = 0, ncyc = 0;

  axi4_s_rd_sequencer_if #(.A_W(A_W), .D_W(D_W), .N(N)) bus ();

  axi4_s_rd_sequencer #(
    .A_W(A_W), .D_W(D_W), .N(N), .TGT_LSB(TGT_LSB), .TIMEOUT(TIMEOUT)
  ) dut (
    .aclk(clk),
    .aresetn(rstn),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [31:0]  arq[$];
  exp_t         expq[$];
  logic [31:0]  tdata [N];
  logic         terr  [N];
  int           tdelay[N];
  logic         noise = 1'b0;
  logic [N-1:0] force_ack = '0;
  int           req_n = 0, req_len = 0, last_pop = 0;
  bit           b2b = 1'b0, popped = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, ncyc);
    end
  endtask

  task automatic drive_ar();
    bus.ar_rd_empty = (arq.size() == 0);
    bus.araddr      = (arq.size() == 0) ? '0 : arq[0];
  endtask

  task automatic drive_tgt();
    int sel;
    sel = -1;
    for (int i = 0; i < N; i++) if (bus.tgt_req[i]) sel = i;
    if (sel >= 0 && rstn) req_n++; else req_n = 0;
    for (int i = 0; i < N; i++) begin
      bus.tgt_rdata[i*D_W +: D_W] = tdata[i];
      bus.tgt_ack[i] = force_ack[i] | (noise && i != sel) | (i == sel && req_n == tdelay[i]);
      bus.tgt_err[i] = (i == sel) ? terr[i] : noise;
    end
  endtask

  task automatic push_read(input logic [31:0] a, input int stall);
    exp_t e;
    int   i;
    i       = int'(a[TGT_LSB +: 2]);
    e.addr  = a;
    e.stall = stall;
    if (!bus.tgt_en[i]) begin
      e.data = '0; e.resp = 2'b11; e.len = 0;
    end else if (tdelay[i] <= int'(TIMEOUT)) begin
      e.data = tdata[i]; e.resp = terr[i] ? 2'b10 : 2'b00; e.len = tdelay[i];
    end else begin
      e.data = '0; e.resp = 2'b10; e.len = int'(TIMEOUT);
    end
    arq.push_back(a);
    expq.push_back(e);
    drive_ar();
  endtask

  task automatic cycle();
    exp_t       e;
    logic [3:0] oh;
    @(negedge clk);
    ncyc++;
    popped = 1'b0;
    if (rstn) begin
      if (bus.tgt_req != '0) begin
        req_len++;
        if (expq.size() > 0) begin
          oh = 4'b0001 << expq[0].addr[TGT_LSB +: 2];
          check("req_sel", bus.tgt_req, oh);
          check("req_addr", bus.tgt_addr, expq[0].addr);
        end
      end
      if (bus.ar_rd_en) begin
        check("pop_nonempty", bus.ar_rd_empty, 0);
        if (b2b && last_pop > 0) check("pop_gap", ncyc - last_pop, 3);
        last_pop = ncyc;
        popped   = 1'b1;
      end
      if (bus.r_wr_en) begin
        check("push_notfull", bus.r_wr_full, 0);
        check("push_expected", expq.size() > 0, 1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          check("rdata", bus.rdata, e.data);
          check("rresp", bus.rresp, e.resp);
          check("tgt_addr", bus.tgt_addr, e.addr);
          check("req_len", req_len, e.len);
          check("latency", ncyc - last_pop, e.len + 1 + e.stall);
        end
        req_len = 0;
      end
    end else begin
      check("rst_ar_rd_en", bus.ar_rd_en, 0);
      check("rst_r_wr_en", bus.r_wr_en, 0);
      req_len = 0;
    end
    @(posedge clk);
    #1;
    if (popped && arq.size() > 0) void'(arq.pop_front());
    drive_ar();
    drive_tgt();
  endtask

  task automatic wait_req(input int limit);
    int n;
    n = 0;
    while (bus.tgt_req == '0 && n < limit) begin
      cycle();
      n++;
    end
    check("wait_req", bus.tgt_req != '0, 1);
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((expq.size() > 0 || bus.busy) && n < limit) begin
      cycle();
      n++;
    end
    check("drain", expq.size(), 0);
    repeat (2) cycle();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ar_rd_en"}, bus.ar_rd_en, 0);
    check({tag, "_r_wr_en"},  bus.r_wr_en, 0);
    check({tag, "_tgt_req"},  bus.tgt_req, 0);
    check({tag, "_busy"},     bus.busy, 0);
    check({tag, "_rdata"},    bus.rdata, 0);
    check({tag, "_rresp"},    bus.rresp, 0);
    check({tag, "_tgt_addr"}, bus.tgt_addr, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", ncyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      tdata[i]  = 32'hA5A5_0000 + 32'(i * 16'h1111);
      terr[i]   = 1'b0;
      tdelay[i] = 1;
    end
    tdata[2]      = 32'hCAFE_F00D;
    bus.tgt_en    = '1;
    bus.r_wr_full = 1'b0;
    bus.tgt_ack   = '0;
    bus.tgt_err   = '0;
    bus.tgt_rdata = '0;
    drive_ar();
    drive_tgt();

    rstn = 1'b0;
    repeat (3) cycle();
    check_idle("reset");
    rstn = 1'b1;
    repeat (3) cycle();
    check_idle("idle");

    // Single read, target 2 acks on its 3rd REQ cycle
    tdelay[2] = 3;
    push_read(32'h0000_2010, 0);
    drain(50);

    // Decode error on an unpopulated target
    bus.tgt_en = 4'b0111;
    push_read(32'h0000_3000, 0);
    drain(50);
    bus.tgt_en = '1;

    // Timeout, then ack exactly in the last allowed cycle, then an error ack
    tdelay[0] = 1000;
    push_read(32'h0000_0040, 0);
    drain(50);
    tdelay[0] = 8;
    push_read(32'h0000_0044, 0);
    drain(50);
    tdelay[1] = 2;
    terr[1]   = 1'b1;
    push_read(32'h0000_1008, 0);
    drain(50);
    terr[1] = 1'b0;

    // Backpressure for 5 PUSH cycles with a second read queued behind
    tdelay[1]     = 1;
    noise         = 1'b1;
    bus.r_wr_full = 1'b1;
    push_read(32'h0000_1100, 5);
    push_read(32'h0000_2200, 0);
    wait_req(20);
    cycle();
    for (int k = 0; k < 5; k++) begin
      check("bp_r_wr_en", bus.r_wr_en, 0);
      check("bp_ar_rd_en", bus.ar_rd_en, 0);
      check("bp_rdata", bus.rdata, tdata[1]);
      check("bp_rresp", bus.rresp, 2'b00);
      cycle();
    end
    bus.r_wr_full = 1'b0;
    drain(50);

    // Back-to-back zero-wait reads
    for (int i = 0; i < N; i++) tdelay[i] = 1;
    b2b      = 1'b1;
    last_pop = 0;
    push_read(32'h0000_0010, 0);
    push_read(32'h0000_1020, 0);
    push_read(32'h0000_2030, 0);
    push_read(32'h0000_3040, 0);
    drain(100);
    b2b = 1'b0;

    // Reset while in REQ with a late ack
    tdelay[3] = 50;
    push_read(32'h0000_3ABC, 0);
    wait_req(20);
    cycle();
    rstn        = 1'b0;
    force_ack   = 4'b1000;
    bus.tgt_ack = bus.tgt_ack | force_ack;
    cycle();
    expq.delete();
    rstn = 1'b1;
    check_idle("midrst");
    cycle();
    force_ack = '0;
    repeat (10) cycle();
    check("final_expq", expq.size(), 0);
    check("final_arq", arq.size(), 0);
    check("final_busy", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
